// File: rtl/pix_shifter.sv
// Two-plane 8-bit pixel serialiser with parallel load, clock inhibit and phase tracking.
// Optional horizontal mirroring is compiled in when PIX_SHIFTER_FLIP_EN is defined.
module pix_shifter (
    input  logic       clk,
    input  logic       n_clr,
    input  logic       clk_inh,
    input  logic       n_load,
    input  logic [7:0] din0,
    input  logic [7:0] din1,
    input  logic       ser0,
    input  logic       ser1,
    input  logic       flip,
    output logic [1:0] pix,
    output logic [2:0] phase,
    output logic       ld_req
);

    logic [7:0] sr0_q, sr0_d;
    logic [7:0] sr1_q, sr1_d;
    logic [2:0] phase_q, phase_d;
    logic       mirror;

`ifdef PIX_SHIFTER_FLIP_EN
    assign mirror = flip;
`else
    logic unused_flip;
    assign unused_flip = flip;
    assign mirror      = 1'b0;
`endif

    // Inhibit beats load, load beats shift; reset is applied in the register process.
    always_comb begin
        sr0_d   = sr0_q;
        sr1_d   = sr1_q;
        phase_d = phase_q;
        if (!clk_inh) begin
            if (!n_load) begin
                sr0_d   = din0;
                sr1_d   = din1;
                phase_d = 3'd0;
            end else begin
                if (mirror) begin
                    sr0_d = {ser0, sr0_q[7:1]};
                    sr1_d = {ser1, sr1_q[7:1]};
                end else begin
                    sr0_d = {sr0_q[6:0], ser0};
                    sr1_d = {sr1_q[6:0], ser1};
                end
                phase_d = phase_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_clr) begin
            sr0_q   <= 8'h00;
            sr1_q   <= 8'h00;
            phase_q <= 3'd0;
        end else begin
            sr0_q   <= sr0_d;
            sr1_q   <= sr1_d;
            phase_q <= phase_d;
        end
    end

    // Outputs come from registered state only; mirroring picks the opposite end bit.
    always_comb begin
        if (mirror) begin
            pix = {sr1_q[0], sr0_q[0]};
        end else begin
            pix = {sr1_q[7], sr0_q[7]};
        end
    end

    assign phase  = phase_q;
    assign ld_req = (phase_q == 3'd7);

endmodule

// File: tb/tb_pix_shifter.sv
// Directed self-checking bench for pix_shifter; flip checks follow PIX_SHIFTER_FLIP_EN.
module tb_pix_shifter;

    logic       clk = 1'b0;
    logic       n_clr, clk_inh, n_load, ser0, ser1, flip;
    logic [7:0] din0, din1;
    logic [1:0] pix;
    logic [2:0] phase;
    logic       ld_req;

    int vectors = 0;
    int miscompares = 0;

    pix_shifter dut (
        .clk(clk), .n_clr(n_clr), .clk_inh(clk_inh), .n_load(n_load),
        .din0(din0), .din1(din1), .ser0(ser0), .ser1(ser1), .flip(flip),
        .pix(pix), .phase(phase), .ld_req(ld_req)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] b0, input logic [7:0] b1);
        din0 = b0; din1 = b1; n_load = 1'b0;
        tick();
        n_load = 1'b1;
    endtask

    task automatic test_reset();
        n_clr = 1'b0; clk_inh = 1'b0; n_load = 1'b0; din0 = 8'hFF; din1 = 8'hFF;
        tick(); tick();
        vectors++;
        if (pix !== 2'b00 || phase !== 3'd0 || ld_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: pix=%b phase=%0d ld_req=%b, want pix=00 phase=0 ld_req=0", pix, phase, ld_req);
        end
        n_clr = 1'b1; n_load = 1'b1;
    endtask

    task automatic test_load_shift();
        logic [1:0] exp_pix [8];
        exp_pix = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01};
        ser0 = 1'b0; ser1 = 1'b0;
        load_byte(8'hA5, 8'h3C);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (pix !== exp_pix[i] || phase !== 3'(i) || ld_req !== (i == 7)) begin
                miscompares++;
                $display("FAIL load_shift[%0d]: pix=%b phase=%0d ld_req=%b, want pix=%b phase=%0d ld_req=%b",
                         i, pix, phase, ld_req, exp_pix[i], i, (i == 7));
            end
            if (i < 7) tick();
        end
    endtask

    task automatic test_back_to_back();
        ser0 = 1'b0; ser1 = 1'b0;
        load_byte(8'hA5, 8'h3C);
        for (int i = 0; i < 7; i++) tick();
        vectors++;
        if (ld_req !== 1'b1 || pix !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b_last_bit: pix=%b ld_req=%b, want pix=01 ld_req=1", pix, ld_req);
        end
        load_byte(8'h80, 8'h00);
        vectors++;
        if (pix !== 2'b01 || phase !== 3'd0 || ld_req !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_new_byte: pix=%b phase=%0d ld_req=%b, want pix=01 phase=0 ld_req=0", pix, phase, ld_req);
        end
        tick();
        vectors++;
        if (pix !== 2'b00 || phase !== 3'd1) begin
            miscompares++;
            $display("FAIL b2b_second_pix: pix=%b phase=%0d, want pix=00 phase=1", pix, phase);
        end
    endtask

    task automatic test_mid_load();
        ser0 = 1'b0; ser1 = 1'b0;
        load_byte(8'hA5, 8'h3C);
        tick(); tick(); tick();
        vectors++;
        if (phase !== 3'd3 || pix !== 2'b10) begin
            miscompares++;
            $display("FAIL mid_load_pre: pix=%b phase=%0d, want pix=10 phase=3", pix, phase);
        end
        load_byte(8'hFF, 8'h00);
        vectors++;
        if (pix !== 2'b01 || phase !== 3'd0) begin
            miscompares++;
            $display("FAIL mid_load: pix=%b phase=%0d, want pix=01 phase=0", pix, phase);
        end
    endtask

    task automatic test_inhibit();
        ser0 = 1'b0; ser1 = 1'b0;
        load_byte(8'hA5, 8'h3C);
        tick(); tick();
        clk_inh = 1'b1; n_load = 1'b0; din0 = 8'h00; din1 = 8'h00; ser0 = 1'b1; ser1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (pix !== 2'b11 || phase !== 3'd2) begin
                miscompares++;
                $display("FAIL inhibit[%0d]: pix=%b phase=%0d, want pix=11 phase=2", i, pix, phase);
            end
        end
        clk_inh = 1'b0; n_load = 1'b1; ser0 = 1'b0; ser1 = 1'b0;
        tick();
        vectors++;
        if (pix !== 2'b10 || phase !== 3'd3) begin
            miscompares++;
            $display("FAIL inhibit_resume: pix=%b phase=%0d, want pix=10 phase=3", pix, phase);
        end
    endtask

    task automatic test_reset_mid_wrap();
        logic [2:0] exp_phase;
        logic [1:0] exp_p;
        ser0 = 1'b0; ser1 = 1'b0;
        load_byte(8'hA5, 8'h3C);
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (phase !== 3'd4 || pix !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_mid_pre: pix=%b phase=%0d, want pix=10 phase=4", pix, phase);
        end
        n_clr = 1'b0; clk_inh = 1'b1; n_load = 1'b0; din0 = 8'hFF; din1 = 8'hFF;
        tick();
        vectors++;
        if (pix !== 2'b00 || phase !== 3'd0 || ld_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: pix=%b phase=%0d ld_req=%b, want pix=00 phase=0 ld_req=0", pix, phase, ld_req);
        end
        n_clr = 1'b1; clk_inh = 1'b0; n_load = 1'b1; ser0 = 1'b1; ser1 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_phase = 3'(k % 8);
            exp_p = (k >= 8) ? 2'b01 : 2'b00;
            vectors++;
            if (pix !== exp_p || phase !== exp_phase || ld_req !== (k == 7)) begin
                miscompares++;
                $display("FAIL wrap[%0d]: pix=%b phase=%0d ld_req=%b, want pix=%b phase=%0d ld_req=%b",
                         k, pix, phase, ld_req, exp_p, exp_phase, (k == 7));
            end
        end
    endtask

    task automatic test_flip();
        ser0 = 1'b0; ser1 = 1'b0; flip = 1'b1;
`ifdef PIX_SHIFTER_FLIP_EN
        load_byte(8'h01, 8'h80);
        vectors++;
        if (pix !== 2'b01 || phase !== 3'd0) begin
            miscompares++;
            $display("FAIL flip_load: pix=%b phase=%0d, want pix=01 phase=0", pix, phase);
        end
        flip = 1'b0;
        #1;
        vectors++;
        if (pix !== 2'b10) begin
            miscompares++;
            $display("FAIL flip_clear: pix=%b, want 10", pix);
        end
        flip = 1'b1; ser0 = 1'b1; ser1 = 1'b0;
        tick();
        vectors++;
        if (pix !== 2'b00 || phase !== 3'd1) begin
            miscompares++;
            $display("FAIL flip_shift: pix=%b phase=%0d, want pix=00 phase=1", pix, phase);
        end
        flip = 1'b0;
        #1;
        vectors++;
        if (pix !== 2'b01) begin
            miscompares++;
            $display("FAIL flip_shift_clear: pix=%b, want 01", pix);
        end
`else
        load_byte(8'h01, 8'h80);
        vectors++;
        if (pix !== 2'b10 || phase !== 3'd0) begin
            miscompares++;
            $display("FAIL flip_ignored_load: pix=%b phase=%0d, want pix=10 phase=0", pix, phase);
        end
        ser0 = 1'b1; ser1 = 1'b0;
        tick();
        vectors++;
        if (pix !== 2'b00 || phase !== 3'd1) begin
            miscompares++;
            $display("FAIL flip_ignored_shift: pix=%b phase=%0d, want pix=00 phase=1", pix, phase);
        end
`endif
        flip = 1'b0;
    endtask

    initial begin
        n_clr = 1'b0; clk_inh = 1'b0; n_load = 1'b1; din0 = 8'h00; din1 = 8'h00;
        ser0 = 1'b0; ser1 = 1'b0; flip = 1'b0;
        test_reset();
        test_load_shift();
        test_back_to_back();
        test_mid_load();
        test_inhibit();
        test_reset_mid_wrap();
        test_flip();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
